// File: rtl/pwm_pkg.sv
//==== pwm_pkg | shared modes, counter direction and index-width helper | rev 1.0 ====
`default_nettype none

package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_multi_if.sv
//==== pwm_multi_if | control/duty-write/status bundle for pwm_multi | rev 1.0 ====
`default_nettype none

interface pwm_multi_if #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
);

  localparam int CH_W = pwm_pkg::idx_w(CHANNELS);

  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      period;
  logic                  mode;
  logic                  wr_en;
  logic [CH_W-1:0]       wr_ch;
  logic [WIDTH-1:0]      wr_data;
  logic [CHANNELS-1:0]   pwm_out;
  logic                  period_done;
  logic [WIDTH-1:0]      cnt;

  modport master (
    output en, prescale, period, mode, wr_en, wr_ch, wr_data,
    input  pwm_out, period_done, cnt
  );

  modport slave (
    input  en, prescale, period, mode, wr_en, wr_ch, wr_data,
    output pwm_out, period_done, cnt
  );

endinterface

`default_nettype wire

// File: rtl/pwm_timebase.sv
//==== pwm_timebase | prescaler, edge/center period counter, boundary pulse | rev 1.0 ====
`default_nettype none

module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [WIDTH-1:0]      period_i,
  input  logic                  mode_i,
  output logic [WIDTH-1:0]      cnt_o,
  output logic [WIDTH-1:0]      cnt_next_o,
  output logic                  load_o,
  output logic                  period_done_o
);

  localparam logic [WIDTH-1:0]      c_ONE     = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] c_PRE_ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      period_act_q, period_act_d;
  logic                  mode_act_q, mode_act_d;
  dir_e                  dir_q, dir_d;
  logic                  done_q, done_d;
  logic                  tick_w, boundary_w, load_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q    <= '0;
      cnt_q        <= '0;
      period_act_q <= '0;
      mode_act_q   <= MODE_EDGE;
      dir_q        <= DIR_UP;
      done_q       <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      mode_act_q   <= mode_act_d;
      dir_q        <= dir_d;
      done_q       <= done_d;
    end
  end

  // >= rather than == so a prescale lowered below pre_cnt still ticks at once
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    tick_w     = 1'b0;
    boundary_w = 1'b0;
    if (!en_i) begin
      pre_cnt_d = '0;
      cnt_d     = '0;
      dir_d     = DIR_UP;
    end else begin
      tick_w    = (pre_cnt_q >= prescale_i);
      pre_cnt_d = tick_w ? '0 : pre_cnt_q + c_PRE_ONE;
      if (tick_w) begin
        if (mode_act_q == MODE_EDGE || period_act_q == '0) begin
          if (cnt_q >= period_act_q) begin
            cnt_d      = '0;
            boundary_w = 1'b1;
          end else begin
            cnt_d = cnt_q + c_ONE;
          end
        end else if (dir_q == DIR_UP) begin
          if (cnt_q >= period_act_q) begin
            cnt_d = cnt_q - c_ONE;
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + c_ONE;
          end
        end else begin
          if (cnt_q <= c_ONE) begin
            cnt_d      = '0;
            dir_d      = DIR_UP;
            boundary_w = 1'b1;
          end else begin
            cnt_d = cnt_q - c_ONE;
          end
        end
      end
    end
  end

  // While disabled the active settings track their inputs every cycle
  always_comb begin
    load_w       = !en_i || boundary_w;
    period_act_d = load_w ? period_i : period_act_q;
    mode_act_d   = load_w ? mode_i : mode_act_q;
    done_d       = boundary_w;
  end

  assign cnt_o         = cnt_q;
  assign cnt_next_o    = cnt_d;
  assign load_o        = load_w;
  assign period_done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/pwm_multi.sv
//==== pwm_multi | CHANNELS PWM outputs on one shared double-buffered timebase | rev 1.0 ====
`default_nettype none

module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8
) (
  input logic        clk,
  input logic        rst,
  pwm_multi_if.slave bus_io
);

  localparam int CH_W = idx_w(CHANNELS);

  logic [WIDTH-1:0]    cnt_w, cnt_next_w;
  logic                load_w, done_w;
  logic [CHANNELS-1:0] next_out_w;
  logic [CHANNELS-1:0] pwm_out_q, pwm_out_d;

  pwm_timebase #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_timebase (
    .clk           (clk),
    .rst           (rst),
    .en_i          (bus_io.en),
    .prescale_i    (bus_io.prescale),
    .period_i      (bus_io.period),
    .mode_i        (bus_io.mode),
    .cnt_o         (cnt_w),
    .cnt_next_o    (cnt_next_w),
    .load_o        (load_w),
    .period_done_o (done_w)
  );

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] shadow_q, shadow_d;
      logic [WIDTH-1:0] duty_act_q, duty_act_d;

      // Active duty loads the pre-write shadow, so a coincident write waits a period
      always_comb begin
        shadow_d   = (bus_io.wr_en && bus_io.wr_ch == CH_W'(i)) ? bus_io.wr_data : shadow_q;
        duty_act_d = load_w ? shadow_q : duty_act_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_q   <= '0;
          duty_act_q <= '0;
        end else begin
          shadow_q   <= shadow_d;
          duty_act_q <= duty_act_d;
        end
      end

      assign next_out_w[i] = (cnt_next_w < duty_act_d);
    end
  endgenerate

  always_comb begin
    pwm_out_d = bus_io.en ? next_out_w : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out_q <= '0;
    end else begin
      pwm_out_q <= pwm_out_d;
    end
  end

  assign bus_io.pwm_out     = pwm_out_q;
  assign bus_io.period_done = done_w;
  assign bus_io.cnt         = cnt_w;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi.sv
//==== tb_pwm_multi | self-checking bench for pwm_multi | rev 1.0 ====
`default_nettype none

module tb_pwm_multi;

  // Five channels so a 3-bit wr_ch can address the out-of-range index 5
  localparam int W  = 8;
  localparam int CH = 5;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pwm_multi_if #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) bus ();

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: phase within period ----------------
  int          m_sh[CH]   = '{default: 0};
  int          m_duty[CH] = '{default: 0};
  int          m_per = 0, m_mode = 0, m_phase = 0, m_sub = 0, m_cnt = 0;
  logic [CH-1:0] m_out = '0;
  logic        m_done = 1'b0;

  function automatic int plen(input int per, input int md);
    return (md != 0 && per != 0) ? 2 * per : per + 1;
  endfunction

  function automatic int cnt_at(input int ph, input int per, input int md);
    return (md != 0 && per != 0 && ph > per) ? 2 * per - ph : ph;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_sh[i]   = 0;
        m_duty[i] = 0;
      end
      m_per = 0; m_mode = 0; m_phase = 0; m_sub = 0; m_cnt = 0;
      m_out = '0; m_done = 1'b0;
    end else begin
      int old_sh[CH];
      old_sh = m_sh;
      if (bus.wr_en && int'(bus.wr_ch) < CH) m_sh[bus.wr_ch] = int'(bus.wr_data);
      m_done = 1'b0;
      if (!bus.en) begin
        m_duty  = old_sh;
        m_per   = int'(bus.period);
        m_mode  = int'(bus.mode);
        m_phase = 0;
        m_sub   = 0;
      end else if (m_sub == int'(bus.prescale)) begin
        m_sub = 0;
        m_phase++;
        if (m_phase >= plen(m_per, m_mode)) begin
          m_phase = 0;
          m_done  = 1'b1;
          m_duty  = old_sh;
          m_per   = int'(bus.period);
          m_mode  = int'(bus.mode);
        end
      end else begin
        m_sub++;
      end
      m_cnt = cnt_at(m_phase, m_per, m_mode);
      for (int i = 0; i < CH; i++) m_out[i] = bus.en && (m_cnt < m_duty[i]);
    end
  end

  always @(negedge clk) begin
    chk("model_cnt", 32'(bus.cnt), 32'(m_cnt));
    chk("model_pwm", 32'(bus.pwm_out), 32'(m_out));
    chk("model_done", 32'(bus.period_done), 32'(m_done));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int ch, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'(ch);
    bus.wr_data = 8'(data);
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.period_done && n < 200);
    if (!bus.period_done) chk({nm, "_timeout"}, 32'(n), 32'(0));
  endtask

  task automatic wait_cnt(input string nm, input int v);
    int n = 0;
    do begin @(negedge clk); n++; end while (int'(bus.cnt) != v && n < 200);
    if (int'(bus.cnt) != v) chk({nm, "_timeout"}, 32'(bus.cnt), 32'(v));
  endtask

  task automatic window(input int ncyc, output int hi[CH], output int dn);
    dn = 0;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    repeat (ncyc) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++) hi[i] += int'(bus.pwm_out[i]);
      dn += int'(bus.period_done);
    end
  endtask

  task automatic cycles_to_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.period_done && n < 200);
  endtask

  task automatic setup(input int pre, input int per, input int md);
    bus.en = 1'b0;
    bus.prescale = 8'(pre);
    bus.period   = 8'(per);
    bus.mode     = md[0];
    repeat (2) @(negedge clk);
  endtask

  int hi[CH];
  int dn, n;
  int exp_seq[8];

  initial begin
    bus.en = 1'b0; bus.prescale = '0; bus.period = '0; bus.mode = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_cnt", 32'(bus.cnt), 32'(0));
    chk("reset_pwm", 32'(bus.pwm_out), 32'(0));
    chk("reset_done", 32'(bus.period_done), 32'(0));
    rst = 1'b0;

    // Edge mode, period 10
    setup(0, 9, 0);
    wr(0, 3); wr(1, 0); wr(2, 10); wr(3, 9);
    @(negedge clk);
    bus.en = 1'b1;
    wait_done("t1");
    window(10, hi, dn);
    chk("t1_ch0_high", 32'(hi[0]), 32'(3));
    chk("t1_ch1_high", 32'(hi[1]), 32'(0));
    chk("t1_ch2_high", 32'(hi[2]), 32'(10));
    chk("t1_ch3_high", 32'(hi[3]), 32'(9));
    chk("t1_done", 32'(dn), 32'(1));

    // Prescaled edge mode
    setup(3, 4, 0);
    wr(0, 2);
    bus.en = 1'b1;
    wait_done("t2");
    window(20, hi, dn);
    chk("t2_ch0_high", 32'(hi[0]), 32'(8));
    chk("t2_done", 32'(dn), 32'(1));

    // Center mode
    setup(0, 4, 1);
    bus.en = 1'b1;
    wait_done("t3");
    exp_seq = '{1, 2, 3, 4, 3, 2, 1, 0};
    dn = 0; hi[0] = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_cnt_seq", 32'(bus.cnt), 32'(exp_seq[k]));
      hi[0] += int'(bus.pwm_out[0]);
      dn += int'(bus.period_done);
    end
    chk("t3_ch0_high", 32'(hi[0]), 32'(3));
    chk("t3_done", 32'(dn), 32'(1));

    // Mid-period duty write
    setup(0, 9, 0);
    wr(0, 3);
    bus.en = 1'b1;
    wait_done("t4");
    wr(0, 7);
    window(9, hi, dn);
    chk("t4_old_period_high", 32'(hi[0]), 32'(2));
    chk("t4_old_period_done", 32'(dn), 32'(1));
    window(10, hi, dn);
    chk("t4_new_period_high", 32'(hi[0]), 32'(7));
    chk("t4_new_period_done", 32'(dn), 32'(1));

    // Write coincident with the boundary
    wait_cnt("t4c", 9);
    wr(0, 1);
    chk("t4c_boundary", 32'(bus.period_done), 32'(1));
    window(10, hi, dn);
    chk("t4c_still_old", 32'(hi[0]), 32'(7));
    window(10, hi, dn);
    chk("t4c_applied", 32'(hi[0]), 32'(1));

    // Out-of-range channel write, then period shrink mid-period
    wr(5, 200);
    wait_done("t5");
    window(10, hi, dn);
    chk("t5_ch1_untouched", 32'(hi[1]), 32'(0));
    chk("t5_ch4_untouched", 32'(hi[4]), 32'(0));
    wait_cnt("t5p", 3);
    bus.period = 8'd4;
    cycles_to_done(n);
    chk("t5_old_period_finish", 32'(n), 32'(7));
    cycles_to_done(n);
    chk("t5_new_period_len", 32'(n), 32'(5));

    // Asynchronous reset mid-period while outputs are high
    wait_cnt("t6", 1);
    chk("t6_outputs_high", 32'(bus.pwm_out[2]), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("t6_async_cnt", 32'(bus.cnt), 32'(0));
    chk("t6_async_pwm", 32'(bus.pwm_out), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      n += int'(bus.pwm_out != '0);
    end
    chk("t6_post_reset_low", 32'(n), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
